// File: rtl/sad_pkg.sv
// Shared constants, SAD width helper and FSM state encoding for the SAD row accumulator.
package sad_pkg;

    localparam int ROWS_DEF  = 8;
    localparam int SUM_W_DEF = 11;

    // Width needed to sum ROWS values of SUM_W bits without overflow.
    function automatic int sad_width(input int sum_w, input int rows);
        return sum_w + $clog2(rows);
    endfunction

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } sad_state_e;

endpackage

// File: rtl/sad_min_tracker.sv
// Tracks the minimum block SAD and its block index; reset/clear restart the search.
// Latency: one cycle after block completion. No backpressure of its own.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int SAD_W = sad_width(SUM_W_DEF, ROWS_DEF)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_done,
    input  logic [SAD_W-1:0] i_sad,
    output logic [SAD_W-1:0] o_min_sad,
    output logic [7:0]       o_min_idx,
    output logic [7:0]       o_blk_idx
);

    logic [SAD_W-1:0] min_sad_q, min_sad_d;
    logic [7:0]       min_idx_q, min_idx_d;
    logic [7:0]       blk_idx_q, blk_idx_d;

    // Strict compare keeps the earliest block on ties.
    always_comb begin
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        blk_idx_d = blk_idx_q;
        if (i_done) begin
            blk_idx_d = blk_idx_q + 8'd1;
            if (i_sad < min_sad_q) begin
                min_sad_d = i_sad;
                min_idx_d = blk_idx_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            min_sad_q <= '1;
            min_idx_q <= '0;
            blk_idx_q <= '0;
        end else begin
            min_sad_q <= min_sad_d;
            min_idx_q <= min_idx_d;
            blk_idx_q <= blk_idx_d;
        end
    end

    assign o_min_sad = min_sad_q;
    assign o_min_idx = min_idx_q;
    assign o_blk_idx = blk_idx_q;

endmodule

// File: rtl/sad_row_accumulator.sv
// Sums ROWS row sums per block into a SAD; optional min tracking under SAD_MIN_TRACK_EN.
// Latency: result valid one cycle after the last row. Stalls rows only while a result is held unconsumed.
module sad_row_accumulator
    import sad_pkg::*;
#(
    parameter  int ROWS  = ROWS_DEF,
    parameter  int SUM_W = SUM_W_DEF,
    localparam int CNT_W = $clog2(ROWS),
    localparam int SAD_W = sad_width(SUM_W, ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_row_valid,
    input  logic [SUM_W-1:0] i_row_sum,
    output logic             o_row_ready,
    output logic [SAD_W-1:0] o_sad,
    output logic             o_sad_valid,
    input  logic             i_sad_ready,
`ifdef SAD_MIN_TRACK_EN
    output logic [SAD_W-1:0] o_min_sad,
    output logic [7:0]       o_min_idx,
    output logic [7:0]       o_blk_idx,
`endif
    output logic [CNT_W-1:0] o_row_cnt
);

    sad_state_e       state_q, state_d;
    logic [SAD_W-1:0] acc_q, acc_d;
    logic [SAD_W-1:0] sad_q, sad_d;
    logic             sad_vld_q, sad_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             row_rdy;
    logic             row_acc;
    logic             last_row;
    logic             handoff;
    logic [SAD_W-1:0] acc_sum;

    // In HOLD a row may only enter when the held result leaves on the same edge.
    assign row_rdy  = (state_q == ST_ACCUM) || i_sad_ready;
    assign row_acc  = i_row_valid && row_rdy;
    assign last_row = row_acc && (cnt_q == CNT_W'(ROWS - 1));
    assign handoff  = sad_vld_q && i_sad_ready;
    assign acc_sum  = acc_q + {{CNT_W{1'b0}}, i_row_sum};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sad_d     = sad_q;
        sad_vld_d = sad_vld_q;
        cnt_d     = cnt_q;
        if (handoff) begin
            sad_vld_d = 1'b0;
            state_d   = ST_ACCUM;
        end
        if (row_acc) begin
            if (last_row) begin
                sad_d     = acc_sum;
                sad_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = ST_HOLD;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            sad_q     <= '0;
            sad_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sad_q     <= sad_d;
            sad_vld_q <= sad_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_row_ready = row_rdy;
    assign o_sad       = sad_q;
    assign o_sad_valid = sad_vld_q;
    assign o_row_cnt   = cnt_q;

`ifdef SAD_MIN_TRACK_EN
    sad_min_tracker #(
        .SAD_W (SAD_W)
    ) u_min_tracker (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (i_clear),
        .i_done    (last_row),
        .i_sad     (acc_sum),
        .o_min_sad (o_min_sad),
        .o_min_idx (o_min_idx),
        .o_blk_idx (o_blk_idx)
    );
`endif

endmodule

// File: tb/tb_sad_row_accumulator.sv
// Directed and random checks of sad_row_accumulator against a block-sum reference model.
module tb_sad_row_accumulator;

    localparam int ROWS  = 8;
    localparam int SUM_W = 11;
    localparam int SAD_W = 14;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst, clr, row_valid, sad_ready;
    logic [SUM_W-1:0] row;
    logic             o_row_ready, o_sad_valid;
    logic [SAD_W-1:0] o_sad;
    logic [CNT_W-1:0] o_row_cnt;
`ifdef SAD_MIN_TRACK_EN
    logic [SAD_W-1:0] o_min_sad;
    logic [7:0]       o_min_idx, o_blk_idx;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: running block sum, pending-result flag, min search.
    int m_cnt = 0, m_sum = 0, m_sad = 0;
    bit m_vld = 0;
    int m_min = (1 << SAD_W) - 1, m_min_idx = 0, m_blk = 0;

    always #5 clk = ~clk;

    sad_row_accumulator #(.ROWS(ROWS), .SUM_W(SUM_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clear     (clr),
        .i_row_valid (row_valid),
        .i_row_sum   (row),
        .o_row_ready (o_row_ready),
        .o_sad       (o_sad),
        .o_sad_valid (o_sad_valid),
        .i_sad_ready (sad_ready),
`ifdef SAD_MIN_TRACK_EN
        .o_min_sad   (o_min_sad),
        .o_min_idx   (o_min_idx),
        .o_blk_idx   (o_blk_idx),
`endif
        .o_row_cnt   (o_row_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_sum = 0; m_sad = 0; m_vld = 0;
        m_min = (1 << SAD_W) - 1; m_min_idx = 0; m_blk = 0;
    endtask

    // One clock: check ready mid-cycle, advance the model, check outputs after the edge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        if (!rst && !clr)
            chk("row_ready", o_row_ready, 32'(!m_vld || sad_ready));
        if (rst || clr) begin
            model_reset();
        end else begin
            acc = row_valid && (!m_vld || sad_ready);
            if (m_vld && sad_ready) m_vld = 0;
            if (acc) begin
                m_sum += int'(row);
                m_cnt++;
                if (m_cnt == ROWS) begin
                    m_sad = m_sum; m_vld = 1; m_sum = 0; m_cnt = 0;
                    if (m_sad < m_min) begin
                        m_min = m_sad; m_min_idx = m_blk;
                    end
                    m_blk = (m_blk + 1) % 256;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("sad_valid", o_sad_valid, 32'(m_vld));
        chk("sad", o_sad, m_sad);
        chk("row_cnt", o_row_cnt, m_cnt);
`ifdef SAD_MIN_TRACK_EN
        chk("min_sad", o_min_sad, m_min);
        chk("min_idx", o_min_idx, m_min_idx);
        chk("blk_idx", o_blk_idx, m_blk);
`endif
    endtask

    task automatic drive(input logic v, input int r);
        row_valid = v;
        row = SUM_W'(r);
        tick();
    endtask

    task automatic block_of(input int first, input int rest);
        drive(1'b1, first);
        for (int i = 1; i < ROWS; i++) drive(1'b1, rest);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; row_valid = 1'b0; row = '0; sad_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", o_row_ready, 1);
        chk("rst_sad", o_sad, 0);
        rst = 1'b0;

        // Rows 1..8 back-to-back.
        sad_ready = 1'b1;
        for (int i = 1; i <= ROWS; i++) begin
            drive(1'b1, i);
            if (i == ROWS - 1) chk("s1_not_yet", o_sad_valid, 0);
        end
        chk("s1_valid", o_sad_valid, 1);
        chk("s1_sad", o_sad, 36);
        drive(1'b0, 0);

        // Full-scale block then a zero block starting on the handoff edge.
        block_of(2040, 2040);
        chk("max_sad", o_sad, 16320);
        block_of(0, 0);
        chk("zero_sad", o_sad, 0);
        chk("zero_valid", o_sad_valid, 1);
        drive(1'b0, 0);

        // Stalled result held for 5 cycles.
        sad_ready = 1'b0;
        block_of(5, 5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7);
            chk("stall_ready", o_row_ready, 0);
            chk("stall_sad", o_sad, 40);
        end
        sad_ready = 1'b1;
        drive(1'b1, 7);
        chk("release_valid", o_sad_valid, 0);
        chk("release_cnt", o_row_cnt, 1);
        for (int i = 1; i < ROWS; i++) drive(1'b1, 7);
        chk("release_sad", o_sad, 56);
        drive(1'b0, 0);

        // Clear after 3 rows discards the offered row.
        for (int i = 0; i < 3; i++) drive(1'b1, 9);
        clr = 1'b1;
        drive(1'b1, 100);
        clr = 1'b0;
        chk("clear_cnt", o_row_cnt, 0);
        chk("clear_valid", o_sad_valid, 0);
        block_of(10, 10);
        chk("clear_sad", o_sad, 80);
        drive(1'b0, 0);

        // Reset mid-block and while holding a result.
        for (int i = 0; i < 4; i++) drive(1'b1, 3);
        rst = 1'b1;
        drive(1'b0, 0);
        chk("rstmid_cnt", o_row_cnt, 0);
        chk("rstmid_ready", o_row_ready, 1);
        rst = 1'b0;
        sad_ready = 1'b0;
        block_of(4, 4);
        chk("hold_valid", o_sad_valid, 1);
        rst = 1'b1;
        drive(1'b1, 4);
        chk("rsthold_valid", o_sad_valid, 0);
        chk("rsthold_sad", o_sad, 0);
        chk("rsthold_ready", o_row_ready, 1);
        rst = 1'b0;
        sad_ready = 1'b1;
        block_of(6, 6);
        chk("post_rst_sad", o_sad, 48);
        drive(1'b0, 0);

`ifdef SAD_MIN_TRACK_EN
        clr = 1'b1;
        drive(1'b0, 0);
        clr = 1'b0;
        chk("min_clear", o_min_sad, (1 << SAD_W) - 1);
        block_of(500, 0);
        block_of(300, 0);
        block_of(300, 0);
        block_of(700, 0);
        drive(1'b0, 0);
        chk("min_final", o_min_sad, 300);
        chk("min_idx_final", o_min_idx, 1);
        chk("blk_idx_final", o_blk_idx, 4);
`endif

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            sad_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)));
        end
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sad_row_accumulator.md
SAD_ROW_ACCUMULATOR -- requirements
Module: sad_row_accumulator

Interface
REQ-001 Parameter ROWS, default 8, number of row sums accumulated per block; power of two, 2..64.
REQ-002 Parameter SUM_W, default 11, width of one row sum.
REQ-003 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_clear  input  1  synchronous abort/restart of the current block and of the search.
REQ-006 i_row_valid  input  1  i_row_sum is valid this cycle.
REQ-007 i_row_sum  input  SUM_W  eight-way absolute-difference row sum from the compressor-array stage.
REQ-008 o_row_ready  output  1  block accepts a row this cycle.
REQ-009 o_sad  output  SUM_W+log2(ROWS)  completed block SAD (14 bits at defaults).
REQ-010 o_sad_valid  output  1  o_sad holds an unconsumed result.
REQ-011 i_sad_ready  input  1  downstream consumes o_sad.
REQ-012 o_row_cnt  output  log2(ROWS)  rows accepted in the current block.

Function
REQ-013 A row SHALL be accepted when i_row_valid && o_row_ready at a rising edge.
REQ-014 The module SHALL add each accepted row zero-extended into an accumulator of width SUM_W+log2(ROWS), with no overflow possible.
REQ-015 FSM states: ACCUM, which accepts rows, and HOLD, which holds a result.
REQ-016 In ACCUM, o_row_ready SHALL be 1.
REQ-017 In HOLD, o_row_ready SHALL equal i_sad_ready: accepting a row while the result is consumed is a pass-through.
REQ-018 When the row that is ROWS-th in the block is accepted, the module SHALL, in the same edge, register accumulator+row into o_sad, set o_sad_valid, clear the accumulator and o_row_cnt (wrap to 0), and go to HOLD.
REQ-019 Latency: o_sad_valid SHALL be high one cycle after the last row is accepted.
REQ-020 In HOLD, when o_sad_valid && i_sad_ready, the module SHALL clear o_sad_valid and return to ACCUM, unless a ROWS-th row is accepted on the same edge, in which case it stays in HOLD with the new result.
REQ-021 A row accepted in the same edge as a result handoff SHALL start the next block.
REQ-022 o_sad SHALL remain stable while o_sad_valid=1 and i_sad_ready=0.
REQ-023 i_clear SHALL have priority over every other event: accumulator, o_row_cnt, o_sad_valid and o_sad are zeroed, state goes to ACCUM, and any row offered that cycle is discarded.

Reset
REQ-024 While i_rst=1 at an edge, the module SHALL set state=ACCUM, accumulator=0, o_row_cnt=0, o_sad=0 and o_sad_valid=0.
REQ-025 i_rst SHALL take priority over i_clear, and a reset mid-block SHALL lose the partial sum.
REQ-026 During reset, o_row_ready SHALL reflect state ACCUM, i.e. 1.

Configuration
REQ-027 With SAD_MIN_TRACK_EN defined, the module SHALL add outputs o_min_sad (same width as o_sad), o_min_idx [7:0] and o_blk_idx [7:0].
REQ-028 With SAD_MIN_TRACK_EN defined, o_blk_idx SHALL count completed blocks, wrapping at 255.
REQ-029 With SAD_MIN_TRACK_EN defined, on each block completion, if the new SAD < o_min_sad (strict), the module SHALL set o_min_sad to the new SAD and o_min_idx to the current o_blk_idx.
REQ-030 With SAD_MIN_TRACK_EN defined, on a tie the earlier index SHALL be kept.
REQ-031 With SAD_MIN_TRACK_EN defined, reset and i_clear SHALL set o_min_sad to all ones and o_min_idx and o_blk_idx to 0.
REQ-032 Without SAD_MIN_TRACK_EN, those ports and registers SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-033 A shared package sad_pkg SHALL hold ROWS_DEF=8, SUM_W_DEF=11, the SAD width function (SUM_W+clog2(ROWS)) and the FSM state enumeration.
REQ-034 Sub-module sad_min_tracker SHALL hold the compare/update logic, instantiated only under SAD_MIN_TRACK_EN.
REQ-035 The accumulate path SHALL be a single adder, not a compressor tree.

Verification
REQ-036 Rows 1..8 are sent back-to-back with i_sad_ready=1 -> o_sad=36 with o_sad_valid high exactly one cycle after row 8, and no stall.
REQ-037 8 rows of 2040 -> o_sad=16320 with no overflow; the next block of zeros -> o_sad=0.
REQ-038 A block completes with i_sad_ready=0 for 5 cycles -> o_row_ready=0 and o_sad stable throughout; on release the next row is accepted on the same edge as the handoff.
REQ-039 i_clear is asserted after 3 rows together with i_row_valid -> the row is discarded, o_row_cnt=0, and the next 8 rows of 10 give o_sad=80.
REQ-040 i_rst is asserted mid-block and while in HOLD -> all outputs are 0, o_row_ready=1, and the subsequent block is correct.
REQ-041 With SAD_MIN_TRACK_EN, blocks with SADs 500, 300, 300, 700 -> o_min_sad=300, o_min_idx=1, o_blk_idx=4.
